// File: rtl/patser_pkg.sv
// Shared types and helpers for the pattern serializer.
// Holds the FSM state encoding and the thermometer-code table function.
package patser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } patser_state_e;

  // Widest pattern word the table function can produce.
  localparam int unsigned PATSER_MAX_W = 64;

  // Table word for a given select.
  // Word i has its low min(i+1, width) bits set; selects past the table
  // (sel >= depth) map to an all-zero word.
  function automatic logic [PATSER_MAX_W-1:0] therm_word(
    input int unsigned sel,
    input int unsigned width,
    input int unsigned depth
  );
    logic [PATSER_MAX_W-1:0] w;
    w = '0;
    if (sel < depth) begin
      for (int unsigned b = 0; b < PATSER_MAX_W; b++) begin
        if ((b <= sel) && (b < width)) w[b] = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/patser_counter.sv
// Bit-position counter for the pattern serializer.
// Synchronous clear has priority over enable; the count saturates at MAXV,
// so it can only get back to zero through the clear input.
module patser_counter #(
  parameter int W    = 3,
  parameter int MAXV = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(MAXV));

  // Count up while enabled, hold at MAXV, clear on request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_en && !w_last) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;

endmodule

// File: rtl/pattern_serializer.sv
// Pattern serializer: shifts out a thermometer-code table word one bit per
// cycle, LSB or MSB first, with back-to-back chaining at the last bit.
// Optional feature macro PATSER_REPEAT_EN adds a repeat input that reloads
// the latched word at the last bit when no new start is requested.
module pattern_serializer
  import patser_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int SEL_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic [SEL_W-1:0] S,
  input  logic             start,
  input  logic             msb_first,
`ifdef PATSER_REPEAT_EN
  // "repeat" is a reserved word, hence the i_ prefix on this port.
  input  logic             i_repeat,
`endif
  output logic             ready,
  output logic             O,
  output logic             valid,
  output logic             last,
  output logic [CNT_W-1:0] bit_idx
);

  patser_state_e    r_state;
  logic [WIDTH-1:0] r_word;
  logic             r_msb;

  logic [WIDTH-1:0] w_tbl;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_pos;
  logic             w_cnt_last;
  logic             w_last;
  logic             w_accept;
  logic             w_reload;
  logic             w_clr;
  logic             w_en;

  assign w_tbl    = WIDTH'(therm_word(32'(S), WIDTH, DEPTH));
  assign w_last   = (r_state == ST_SHIFT) && w_cnt_last;
  assign ready    = (r_state == ST_IDLE) || w_last;
  assign w_accept = start && ready;

`ifdef PATSER_REPEAT_EN
  assign w_reload = w_last && !start && i_repeat;
`else
  assign w_reload = 1'b0;
`endif

  // Every word boundary restarts the count: a new accept, a repeat reload,
  // or the drop back to idle (so bit_idx reads 0 while idle).
  assign w_clr = w_last || w_accept;
  assign w_en  = (r_state == ST_SHIFT);

  patser_counter #(
    .W    (CNT_W),
    .MAXV (WIDTH - 1)
  ) u_cnt (
    .clk    (CLK),
    .rst    (CLEAR),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_cnt  (w_cnt),
    .o_last (w_cnt_last)
  );

  // Control FSM: latch word and order on accept, hold them through the word
  // (and across repeat reloads), fall back to idle after an unchained last bit.
  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_msb   <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_word  <= w_tbl;
      r_msb   <= msb_first;
    end else if (w_last && !w_reload) begin
      r_state <= ST_IDLE;
    end
  end

  // Emission position -> word bit position.
  assign w_pos   = r_msb ? (CNT_W'(WIDTH - 1) - w_cnt) : w_cnt;

  assign valid   = (r_state == ST_SHIFT);
  assign O       = valid && r_word[w_pos];
  assign last    = w_last;
  assign bit_idx = w_cnt;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer (WIDTH=8, DEPTH=8 main instance,
// DEPTH=6 side instance for the out-of-table select).
module tb_pattern_serializer;

  logic       CLK;
  logic       CLEAR;
  logic [2:0] S;
  logic       start;
  logic       start6;
  logic       msb_first;
  logic       rpt;
  logic       ready, O, valid, last;
  logic [2:0] bit_idx;
  logic       ready6, O6, valid6, last6;
  logic [2:0] idx6;

  int n_cmp = 0;
  int n_bad = 0;

  pattern_serializer #(.WIDTH(8), .DEPTH(8)) dut (
    .CLK       (CLK),
    .CLEAR     (CLEAR),
    .S         (S),
    .start     (start),
    .msb_first (msb_first),
`ifdef PATSER_REPEAT_EN
    .i_repeat  (rpt),
`endif
    .ready     (ready),
    .O         (O),
    .valid     (valid),
    .last      (last),
    .bit_idx   (bit_idx)
  );

  pattern_serializer #(.WIDTH(8), .DEPTH(6)) dut6 (
    .CLK       (CLK),
    .CLEAR     (CLEAR),
    .S         (S),
    .start     (start6),
    .msb_first (msb_first),
`ifdef PATSER_REPEAT_EN
    .i_repeat  (1'b0),
`endif
    .ready     (ready6),
    .O         (O6),
    .valid     (valid6),
    .last      (last6),
    .bit_idx   (idx6)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] s;
    logic       msb;
    logic [7:0] seq;   // seq[k] = k-th emitted bit
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic eo,
                         input logic el, input logic er, input int ei);
    chk({tag, ".valid"},   32'(valid),   32'(ev));
    chk({tag, ".O"},       32'(O),       32'(eo));
    chk({tag, ".last"},    32'(last),    32'(el));
    chk({tag, ".ready"},   32'(ready),   32'(er));
    chk({tag, ".bit_idx"}, 32'(bit_idx), 32'(ei));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One single-shot word followed by the idle check.
  task automatic run_vec(input string tag, input logic [2:0] s, input logic msb,
                         input logic [7:0] seq);
    S = s; msb_first = msb; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_out(tag, 1'b1, seq[k], k == 7, k == 7, k);
      step();
    end
    chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  // Reference: thermometer word of the 8-entry table, in emission order.
  function automatic logic [7:0] ref_seq(input int s, input logic msb);
    logic [7:0] w;
    logic [7:0] r;
    int n;
    n = (s + 1 < 8) ? s + 1 : 8;
    w = (s < 8) ? 8'((1 << n) - 1) : 8'h00;
    for (int k = 0; k < 8; k++) r[k] = msb ? w[7 - k] : w[k];
    return r;
  endfunction

  initial begin
    logic       mq[$];
    logic [7:0] saved;
    logic [7:0] sq;
    logic       rd;

    CLEAR = 1'b1; S = '0; start = 1'b0; start6 = 1'b0; msb_first = 1'b0; rpt = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge CLK);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("reset.valid6", 32'(valid6), 32'd0);
    CLEAR = 1'b0;
    step();

    // Table-driven single-shot words.
    vecs[0] = '{s: 3'd3, msb: 1'b0, seq: 8'b0000_1111};
    vecs[1] = '{s: 3'd3, msb: 1'b1, seq: 8'b1111_0000};
    vecs[2] = '{s: 3'd0, msb: 1'b0, seq: 8'b0000_0001};
    vecs[3] = '{s: 3'd7, msb: 1'b1, seq: 8'b1111_1111};
    vecs[4] = '{s: 3'd1, msb: 1'b1, seq: 8'b1100_0000};
    vecs[5] = '{s: 3'd5, msb: 1'b0, seq: 8'b0011_1111};
    for (int v = 0; v < 6; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].s, vecs[v].msb, vecs[v].seq);
      step();
    end

    // Back-to-back: start held, S=0 then S=7 at the last cycle.
    S = 3'd0; msb_first = 1'b0; start = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      chk_out($sformatf("b2b%0d", k), 1'b1, (k < 8) ? (k == 0) : 1'b1,
              (k % 8) == 7, (k % 8) == 7, k % 8);
      if (k == 7)  S = 3'd7;
      if (k == 15) start = 1'b0;
      step();
    end
    chk_out("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step();

    // Asynchronous clear in the middle of a word.
    S = 3'd7; msb_first = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("clr.pre_idx", 32'(bit_idx), 32'd4);
    CLEAR = 1'b1;
    #1;
    chk_out("clr.async", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step();
    CLEAR = 1'b0;
    run_vec("clr.next", 3'd1, 1'b0, 8'b0000_0011);
    step();

    // Out-of-table select on the DEPTH=6 instance yields zeros.
    S = 3'd7; msb_first = 1'b0; start6 = 1'b1;
    step();
    start6 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("d6.valid%0d", k), 32'(valid6), 32'd1);
      chk($sformatf("d6.O%0d", k),     32'(O6),     32'd0);
      chk($sformatf("d6.last%0d", k),  32'(last6),  32'(k == 7));
      step();
    end
    chk("d6.idle", 32'(valid6), 32'd0);

`ifdef PATSER_REPEAT_EN
    // Repeat three words of S=2, dropping repeat during the third.
    S = 3'd2; msb_first = 1'b0; rpt = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk_out($sformatf("rep%0d", k), 1'b1, (k % 8) < 3,
              (k % 8) == 7, (k % 8) == 7, k % 8);
      if (k == 16) rpt = 1'b0;
      step();
    end
    chk_out("rep.idle", 1'b0, 1'b0, 1'b0, 1'b1, 0);
`endif
    step();

    // Randomized traffic against a queue-of-bits model.
    mq.delete();
    saved = '0;
    for (int c = 0; c < 400; c++) begin
      chk_out($sformatf("rnd%0d", c), mq.size() > 0,
              (mq.size() > 0) ? mq[0] : 1'b0, mq.size() == 1,
              mq.size() <= 1, (mq.size() > 0) ? 8 - mq.size() : 0);
      if ($urandom_range(0, 39) == 0) begin
        start = 1'b0;
        CLEAR = 1'b1;
        #1;
        chk_out($sformatf("rnd%0d.clr", c), 1'b0, 1'b0, 1'b0, 1'b1, 0);
        mq.delete();
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
      end else begin
        start     = ($urandom_range(0, 2) == 0);
        S         = 3'($urandom_range(0, 7));
        msb_first = 1'($urandom_range(0, 1));
`ifdef PATSER_REPEAT_EN
        rpt       = ($urandom_range(0, 3) == 0);
`endif
        rd = (mq.size() <= 1);
        if (start && rd) begin
          sq = ref_seq(int'(S), msb_first);
          saved = sq;
          mq.delete();
          for (int k = 0; k < 8; k++) mq.push_back(sq[k]);
        end else if (mq.size() == 1 && rpt) begin
`ifdef PATSER_REPEAT_EN
          mq.delete();
          for (int k = 0; k < 8; k++) mq.push_back(saved[k]);
`else
          void'(mq.pop_front());
`endif
        end else if (mq.size() > 0) begin
          void'(mq.pop_front());
        end
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per pattern word (WIDTH >= 2).
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of pattern words in the table (DEPTH >= 2).
REQ-003 SHALL derive SEL_W = clog2(DEPTH) and CNT_W = clog2(WIDTH) as localparams.
REQ-004 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port CLEAR  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port S  input  SEL_W  pattern select, sampled on accept.
REQ-007 SHALL have port start  input  1  request to serialize pattern S.
REQ-008 SHALL have port msb_first  input  1  bit order, sampled on accept (1 = bit WIDTH-1 first).
REQ-009 SHALL have port ready  output  1  start is accepted this cycle if asserted.
REQ-010 SHALL have port O  output  1  serial data bit; 0 whenever valid=0.
REQ-011 SHALL have port valid  output  1  O carries a pattern bit.
REQ-012 SHALL have port last  output  1  current bit is the final bit of the word.
REQ-013 SHALL have port bit_idx  output  CNT_W  index (0..WIDTH-1) of the bit currently on O, in emission order.

Function
REQ-014 SHALL hold a read-only table where word i has its low min(i+1, WIDTH) bits set and all other bits clear (thermometer code).
REQ-015 SHALL use a word of all zeros when S >= DEPTH.
REQ-016 SHALL implement the FSM states IDLE and SHIFT.
REQ-017 SHALL drive ready = 1 in IDLE, and in SHIFT only while last = 1.
REQ-018 SHALL accept on a rising edge with start=1 and ready=1: latch the table word and msb_first, clear the counter, enter or stay in SHIFT.
REQ-019 SHALL present bit 0 of an accepted word in the first cycle after the accepting edge; the latency from accept to first bit is 1 cycle.
REQ-020 SHALL present one bit per cycle for exactly WIDTH cycles, with valid=1 throughout.
REQ-021 SHALL emit bits in the order WIDTH-1 down to 0 when msb_first=1, and 0 up to WIDTH-1 otherwise.
REQ-022 SHALL assert last only while bit_idx = WIDTH-1.
REQ-023 SHALL, when last=1 and start=0, return to IDLE at the next edge (valid=0, O=0).
REQ-024 SHALL, when last=1 and start=1, load the next word with no gap cycle (back-to-back).
REQ-025 SHALL ignore start whenever ready=0; changes to S and msb_first mid-word SHALL have no effect.
REQ-026 SHALL wrap the counter from WIDTH-1 to 0 only on a back-to-back accept; it SHALL never overflow.

Reset
REQ-027 SHALL, while CLEAR=1, force state=IDLE, O=0, valid=0, last=0, bit_idx=0 and ready=1, immediately and without waiting for CLK.
REQ-028 SHALL abort any word in progress on CLEAR with no residual output; the first edge after CLEAR falls SHALL accept start normally.

Configuration
REQ-029 SHALL use macro PATSER_REPEAT_EN; when it is defined, the design SHALL add port repeat (input, 1 bit).
REQ-030 SHALL, with PATSER_REPEAT_EN defined, when last=1, repeat=1 and start=0, reload the same latched word and order with no gap, continuing until repeat=0 at a last cycle.
REQ-031 SHALL, with PATSER_REPEAT_EN defined, give start priority over repeat when both are 1 at a last cycle.
REQ-032 SHALL, without PATSER_REPEAT_EN, have no repeat port and behave single-shot per REQ-023/024.

Structure
REQ-033 SHALL take the state enum and the thermometer-word function from the shared package patser_pkg.
REQ-034 SHALL implement the bit counter as sub-module patser_counter (CNT_W-wide, with synchronous load-zero, enable and last-detect) and SHALL instantiate it once.

Verification (WIDTH=8, DEPTH=8 unless stated)
REQ-035 SHALL check: CLEAR=1 for 3 cycles -> O=0, valid=0, last=0, ready=1, bit_idx=0.
REQ-036 SHALL check: S=3, msb_first=0, one-cycle start -> O = 1,1,1,1,0,0,0,0 over 8 cycles, last only on the 8th, then ready=1 and valid=0.
REQ-037 SHALL check: S=3, msb_first=1 -> O = 0,0,0,0,1,1,1,1.
REQ-038 SHALL check: start held with S=0, then S=7 at the last cycle -> 16 consecutive valid cycles: 1,0,0,0,0,0,0,0 then eight 1s.
REQ-039 SHALL check: CLEAR pulsed at bit_idx=4 of S=7 -> valid=0 and O=0 within the same cycle; the next start with S=1 outputs 1,1,0,0,0,0,0,0.
REQ-040 SHALL check: with DEPTH=6 and S=7 -> eight valid zeros; with PATSER_REPEAT_EN, repeat=1 and S=2 -> 1,1,1,0,0,0,0,0 repeated for 3 words, stopping after repeat drops.
